// File: rtl/hssdrc_sys_slave_model.sv
// -----------------------------------------------------------------------------
// hssdrc_sys_slave_model
//
// Synthesizable stand-in for the HSSDRC controller on its system command
// interface. Write, read and refresh commands are served from a small internal
// RAM instead of SDRAM. The master sees the same ready / use_wdata /
// vld_rdata / chid_o handshake as on the real controller, so master-side
// logic can be developed without the SDRAM path.
//
// Handshake (the one place it is written down):
//   * A command is accepted in a cycle where ready=1 and at least one of
//     write/read/refr is high. Strobes while ready=0 are ignored. If several
//     strobes are high together, write beats read, and read beats refr. The
//     sticky cmd_err flag records that this happened.
//   * After a write is accepted, use_wdata is high for burst+1 cycles. In each
//     of these cycles the master drives wdata/wdatam for the next beat. The
//     beat is stored at the clock edge that ends that cycle.
//   * After a read is accepted, one beat is issued per cycle for burst+1
//     cycles. Each beat appears RD_LAT cycles later, with vld_rdata=1 and
//     rdata/chid_o valid. Beats come back in issue order. No back-pressure.
//   * ready, use_wdata and vld_rdata are forced low in any cycle where reset
//     or sclr is high.
//
// Ports:
//   clk, reset, sclr       clock, synchronous active-high reset / clear
//   write, read, refr      command strobes
//   rowa, cola, ba, burst  command address fields (beats = burst + 1)
//   chid_i                 channel id of the command
//   wdata, wdatam          write data and byte mask (1 = byte not written)
//   ready                  command can be accepted this cycle
//   use_wdata              master must present the next write beat
//   vld_rdata              rdata / chid_o carry a returned read beat
//   chid_o, rdata          channel id and data of the returned beat
//   cmd_err                sticky multiple-strobe indication
//   dbg_state_o            current FSM state (IDLE=0, WRITE=1, READ=2, REFR=3)
// -----------------------------------------------------------------------------
module hssdrc_sys_slave_model #(
   parameter int ROWA_W   = 12,
   parameter int COLA_W   = 8,
   parameter int BA_W     = 2,
   parameter int BURST_W  = 4,
   parameter int CHID_W   = 4,
   parameter int DATA_W   = 32,
   parameter int MEM_AW   = 10,
   parameter int RD_LAT   = 2,
   parameter int REFR_CYC = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sclr,
   input  logic                write,
   input  logic                read,
   input  logic                refr,
   input  logic [ROWA_W-1:0]   rowa,
   input  logic [COLA_W-1:0]   cola,
   input  logic [BA_W-1:0]     ba,
   input  logic [BURST_W-1:0]  burst,
   input  logic [CHID_W-1:0]   chid_i,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wdatam,
   output logic                ready,
   output logic                use_wdata,
   output logic                vld_rdata,
   output logic [CHID_W-1:0]   chid_o,
   output logic [DATA_W-1:0]   rdata,
   output logic                cmd_err,
   output logic [1:0]          dbg_state_o
);

   localparam int BE_W    = DATA_W / 8;
   localparam int MEM_D   = 1 << MEM_AW;
   localparam int REFR_CW = (REFR_CYC > 1) ? $clog2(REFR_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_REFR  = 2'd3
   } state_e;

   // ---------------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------------
   state_e               state_q, state_d;
   logic                 ready_q, ready_d;
   logic [ROWA_W-1:0]    rowa_q, rowa_d;
   logic [COLA_W-1:0]    cola_q, cola_d;
   logic [BA_W-1:0]      ba_q, ba_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic [CHID_W-1:0]    chid_q, chid_d;
   // The beat counter has the same width as burst. It never has to hold
   // burst+1, because the last beat is detected by beat_q == burst_q.
   logic [BURST_W-1:0]   beat_q, beat_d;
   logic [REFR_CW-1:0]   refr_q, refr_d;
   logic                 cmd_err_q, cmd_err_d;

   logic                 clr;
   logic                 any_cmd;
   logic                 multi_cmd;
   logic                 accept;

   assign clr       = reset | sclr;
   assign any_cmd   = write | read | refr;
   assign multi_cmd = (write & read) | (write & refr) | (read & refr);
   assign accept    = ready & any_cmd;

   // ---------------------------------------------------------------------------
   // Beat address. The column wraps inside the row. The RAM address is
   // {ba, rowa, col} truncated to MEM_AW bits.
   // ---------------------------------------------------------------------------
   logic [COLA_W-1:0]    col_cur;
   logic [MEM_AW-1:0]    mem_addr;

   assign col_cur  = cola_q + COLA_W'(beat_q);
   assign mem_addr = MEM_AW'({ba_q, rowa_q, col_cur});

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      rowa_d    = rowa_q;
      cola_d    = cola_q;
      ba_d      = ba_q;
      burst_d   = burst_q;
      chid_d    = chid_q;
      beat_d    = beat_q;
      refr_d    = refr_q;
      cmd_err_d = cmd_err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rowa_d  = rowa;
               cola_d  = cola;
               ba_d    = ba;
               burst_d = burst;
               chid_d  = chid_i;
               beat_d  = '0;
               refr_d  = '0;
               if (write) begin
                  state_d = ST_WRITE;
               end else if (read) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_REFR;
               end
               if (multi_cmd) begin
                  cmd_err_d = 1'b1;
               end
            end
         end

         ST_WRITE, ST_READ: begin
            if (beat_q == burst_q) begin
               state_d = ST_IDLE;
               beat_d  = '0;
            end else begin
               beat_d  = beat_q + 1'b1;
            end
         end

         ST_REFR: begin
            if (refr_q == REFR_CW'(REFR_CYC - 1)) begin
               state_d = ST_IDLE;
               refr_d  = '0;
            end else begin
               refr_d  = refr_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // ready is registered: it follows the state we are about to enter.
      ready_d = (state_d == ST_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         // Set during reset so that ready rises in the first cycle reset or
         // sclr is low. The output gate keeps ready low while clr is high.
         ready_q   <= 1'b1;
         rowa_q    <= '0;
         cola_q    <= '0;
         ba_q      <= '0;
         burst_q   <= '0;
         chid_q    <= '0;
         beat_q    <= '0;
         refr_q    <= '0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         rowa_q    <= rowa_d;
         cola_q    <= cola_d;
         ba_q      <= ba_d;
         burst_q   <= burst_d;
         chid_q    <= chid_d;
         beat_q    <= beat_d;
         refr_q    <= refr_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Internal RAM. It has no reset, so its contents survive reset and sclr.
   // A write happens only in a cycle where use_wdata is high, and use_wdata is
   // already low in a reset/sclr cycle. So an interrupted burst keeps its
   // earlier beats and writes nothing after the interrupt.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [MEM_D];
   logic              rd_issue;

   always_ff @(posedge clk) begin
      if (use_wdata) begin
         for (int k = 0; k < BE_W; k++) begin
            if (!wdatam[k]) begin
               mem_q[mem_addr][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
   end

   assign rd_issue = (state_q == ST_READ) & ~clr;

   // ---------------------------------------------------------------------------
   // Read return pipeline. Stage 0 takes the RAM word in the issue cycle.
   // This fixes the read data at issue, so a later write cannot change it.
   // The beat then moves through RD_LAT-1 more stages. Clearing the valids
   // drops every in-flight beat.
   // ---------------------------------------------------------------------------
   logic [RD_LAT-1:0] pv_q;
   logic [DATA_W-1:0] pd_q [RD_LAT];
   logic [CHID_W-1:0] pc_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (clr) begin
         pv_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pd_q[i] <= '0;
            pc_q[i] <= '0;
         end
      end else begin
         pv_q[0] <= rd_issue;
         if (rd_issue) begin
            pd_q[0] <= mem_q[mem_addr];
            pc_q[0] <= chid_q;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            if (pv_q[i-1]) begin
               pd_q[i] <= pd_q[i-1];
               pc_q[i] <= pc_q[i-1];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ready       = ready_q & ~clr;
   assign use_wdata   = (state_q == ST_WRITE) & ~clr;
   assign vld_rdata   = pv_q[RD_LAT-1] & ~clr;
   assign rdata       = pd_q[RD_LAT-1];
   assign chid_o      = pc_q[RD_LAT-1];
   assign cmd_err     = cmd_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hssdrc_sys_slave_model.sv
// -----------------------------------------------------------------------------
// tb_hssdrc_sys_slave_model
//
// Directed bench for hssdrc_sys_slave_model. The driver tasks issue commands.
// For every read beat they push the hand-computed data, channel id and return
// cycle into expectation queues. A monitor on the falling edge pops one entry
// per vld_rdata cycle and compares it. A vld_rdata with no entry queued is an
// error. The driver tasks also check the ready, use_wdata and refresh timing.
// -----------------------------------------------------------------------------
module tb_hssdrc_sys_slave_model;

   localparam int RD_LAT   = 2;
   localparam int REFR_CYC = 4;

   // ---------------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        reset, sclr;
   logic        write, read, refr;
   logic [11:0] rowa;
   logic [7:0]  cola;
   logic [1:0]  ba;
   logic [3:0]  burst;
   logic [3:0]  chid_i;
   logic [31:0] wdata;
   logic [3:0]  wdatam;
   logic        ready, use_wdata, vld_rdata, cmd_err;
   logic [3:0]  chid_o;
   logic [31:0] rdata;
   logic [1:0]  dbg_state;

   hssdrc_sys_slave_model #(
      .ROWA_W(12), .COLA_W(8), .BA_W(2), .BURST_W(4), .CHID_W(4),
      .DATA_W(32), .MEM_AW(10), .RD_LAT(RD_LAT), .REFR_CYC(REFR_CYC)
   ) dut (
      .clk(clk), .reset(reset), .sclr(sclr),
      .write(write), .read(read), .refr(refr),
      .rowa(rowa), .cola(cola), .ba(ba), .burst(burst), .chid_i(chid_i),
      .wdata(wdata), .wdatam(wdatam),
      .ready(ready), .use_wdata(use_wdata), .vld_rdata(vld_rdata),
      .chid_o(chid_o), .rdata(rdata), .cmd_err(cmd_err),
      .dbg_state_o(dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Clock and cycle counter
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [3:0]  exp_chid_q[$];
   int          exp_cyc_q[$];
   logic [31:0] exp_buf[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: one comparison per returned beat
   // ---------------------------------------------------------------------------
   logic [31:0] mon_d;
   logic [3:0]  mon_c;
   int          mon_t;

   always @(negedge clk) begin
      if (vld_rdata !== 1'b0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: vld_rdata=%b at cycle %0d (chid %h data %h), no beat expected",
                     vld_rdata, cyc, chid_o, rdata);
         end else begin
            mon_d = exp_q.pop_front();
            mon_c = exp_chid_q.pop_front();
            mon_t = exp_cyc_q.pop_front();
            if (rdata !== mon_d || chid_o !== mon_c || cyc != mon_t) begin
               n_fail++;
               $display("FAIL rd_beat: got data %h chid %h cycle %0d, expected data %h chid %h cycle %0d",
                        rdata, chid_o, cyc, mon_d, mon_c, mon_t);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds a command for one cycle once ready is high. c0 is that cycle.
   task automatic cmd(input logic w, input logic r, input logic f,
                      input logic [1:0] b, input logic [11:0] ra, input logic [7:0] ca,
                      input logic [3:0] bu, input logic [3:0] ch, output int c0);
      int waited;
      waited = 0;
      while (ready !== 1'b1 && waited < 50) begin
         step();
         waited++;
      end
      if (ready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cmd_ready_timeout: ready=%b after %0d cycles, expected 1", ready, waited);
      end
      write = w; read = r; refr = f;
      ba = b; rowa = ra; cola = ca; burst = bu; chid_i = ch;
      c0 = cyc;
      step();
      write = 1'b0; read = 1'b0; refr = 1'b0;
   endtask

   // Write burst: beat i carries base + i.
   task automatic do_write(input logic [1:0] b, input logic [11:0] ra, input logic [7:0] ca,
                           input logic [3:0] bu, input logic [3:0] ch,
                           input logic [31:0] base, input logic [3:0] mask, input logic also_read);
      int c0, n, good;
      n = int'(bu) + 1;
      good = 1;
      cmd(1'b1, also_read, 1'b0, b, ra, ca, bu, ch, c0);
      for (int i = 0; i < n; i++) begin
         wdata  = base + 32'(i);
         wdatam = mask;
         if (use_wdata !== 1'b1 || ready !== 1'b0) good = 0;
         step();
      end
      wdata  = '0;
      wdatam = '0;
      check("wr_use_wdata_window", 32'(good), 32'd1);
      check("wr_ready_back", {30'd0, use_wdata, ready}, 32'd1);
   endtask

   // Read burst: beat i is expected to return exp_buf[i].
   task automatic do_read(input logic [1:0] b, input logic [11:0] ra, input logic [7:0] ca,
                          input logic [3:0] bu, input logic [3:0] ch);
      int c0, n, good;
      n = int'(bu) + 1;
      good = 1;
      cmd(1'b0, 1'b1, 1'b0, b, ra, ca, bu, ch, c0);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(exp_buf[i]);
         exp_chid_q.push_back(ch);
         exp_cyc_q.push_back(c0 + 1 + RD_LAT + i);
      end
      for (int i = 0; i < n; i++) begin
         if (ready !== 1'b0 || use_wdata !== 1'b0) good = 0;
         step();
      end
      check("rd_busy_window", 32'(good), 32'd1);
      check("rd_ready_back", 32'(ready), 32'd1);
   endtask

   // Refresh: ready must be low for exactly REFR_CYC cycles. With stray=1, the
   // write and read strobes stay high during the busy cycles.
   task automatic do_refr(input logic stray);
      int c0, low_cnt, waited;
      cmd(1'b0, 1'b0, 1'b1, 2'd0, 12'd0, 8'd0, 4'd0, 4'd0, c0);
      low_cnt = 0;
      waited  = 0;
      write = stray; read = stray;
      while (ready !== 1'b1 && waited < 20) begin
         if (use_wdata !== 1'b0) low_cnt = 100;
         low_cnt++;
         waited++;
         step();
      end
      write = 1'b0; read = 1'b0;
      check("refr_busy_cycles", 32'(low_cnt), 32'(REFR_CYC));
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         step();
         waited++;
      end
      while (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rd_missing: beat data %h chid %h due cycle %0d never returned",
                  exp_q[0], exp_chid_q[0], exp_cyc_q[0]);
         void'(exp_q.pop_front());
         void'(exp_chid_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int c0, sclr_cyc;
      reset = 1'b1; sclr = 1'b0;
      write = 1'b0; read = 1'b0; refr = 1'b0;
      rowa = '0; cola = '0; ba = '0; burst = '0; chid_i = '0;
      wdata = '0; wdatam = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_use_wdata", 32'(use_wdata), 32'd0);
      check("rst_vld_rdata", 32'(vld_rdata), 32'd0);
      check("rst_cmd_err", 32'(cmd_err), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_chid_o", 32'(chid_o), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", 32'(ready), 32'd1);

      // Write then read, burst 3.
      do_write(2'd1, 12'd5, 8'h10, 4'd3, 4'd2, 32'hA0, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) exp_buf[i] = 32'hA0 + 32'(i);
      do_read(2'd1, 12'd5, 8'h10, 4'd3, 4'd2);
      wait_drain();

      // Masked write over a zero word.
      do_write(2'd0, 12'd7, 8'h80, 4'd0, 4'd3, 32'h0000_0000, 4'b0000, 1'b0);
      do_write(2'd0, 12'd7, 8'h80, 4'd0, 4'd3, 32'hFFFF_FFFF, 4'b0101, 1'b0);
      exp_buf[0] = 32'hFF00_FF00;
      do_read(2'd0, 12'd7, 8'h80, 4'd0, 4'd3);
      wait_drain();

      // Column wrap inside the row.
      do_write(2'd3, 12'd6, 8'hFE, 4'd3, 4'd4, 32'd1, 4'b0000, 1'b0);
      exp_buf[0] = 32'd1; do_read(2'd3, 12'd6, 8'hFE, 4'd0, 4'd4);
      exp_buf[0] = 32'd2; do_read(2'd3, 12'd6, 8'hFF, 4'd0, 4'd4);
      exp_buf[0] = 32'd3; do_read(2'd3, 12'd6, 8'h00, 4'd0, 4'd4);
      exp_buf[0] = 32'd4; do_read(2'd3, 12'd6, 8'h01, 4'd0, 4'd4);
      for (int i = 0; i < 4; i++) exp_buf[i] = 32'd1 + 32'(i);
      do_read(2'd3, 12'd6, 8'hFE, 4'd3, 4'd5);
      wait_drain();

      // Back-to-back reads (chid 1 then chid 7), then a refresh.
      exp_buf[0] = 32'hA0;
      do_read(2'd1, 12'd5, 8'h10, 4'd0, 4'd1);
      exp_buf[0] = 32'hA1; exp_buf[1] = 32'hA2;
      do_read(2'd1, 12'd5, 8'h11, 4'd1, 4'd7);
      do_refr(1'b0);
      wait_drain();

      // Strobes while ready=0 have no effect.
      do_refr(1'b1);
      check("stray_cmd_err", 32'(cmd_err), 32'd0);
      step();
      check("stray_idle", {30'd0, use_wdata, ready}, 32'd1);
      check("stray_state", 32'(dbg_state), 32'd0);

      // Write and read together: the write wins and cmd_err sticks.
      do_write(2'd2, 12'd9, 8'h30, 4'd1, 4'd5, 32'h77, 4'b0000, 1'b1);
      check("cmd_err_set", 32'(cmd_err), 32'd1);
      exp_buf[0] = 32'h77; exp_buf[1] = 32'h78;
      do_read(2'd2, 12'd9, 8'h30, 4'd1, 4'd5);
      wait_drain();
      check("cmd_err_sticky", 32'(cmd_err), 32'd1);

      // Maximum burst: 16 beats.
      do_write(2'd0, 12'd0, 8'h20, 4'd15, 4'd6, 32'h500, 4'b0000, 1'b0);
      for (int i = 0; i < 16; i++) exp_buf[i] = 32'h500 + 32'(i);
      do_read(2'd0, 12'd0, 8'h20, 4'd15, 4'd6);
      wait_drain();

      // sclr during the 3rd beat of a burst-7 read.
      do_write(2'd2, 12'd3, 8'h40, 4'd7, 4'd8, 32'h100, 4'b0000, 1'b0);
      cmd(1'b0, 1'b1, 1'b0, 2'd2, 12'd3, 8'h40, 4'd7, 4'd8, c0);
      sclr_cyc = c0 + 3;
      for (int i = 0; i < 8; i++) begin
         if (c0 + 1 + RD_LAT + i < sclr_cyc) begin
            exp_q.push_back(32'h100 + 32'(i));
            exp_chid_q.push_back(4'd8);
            exp_cyc_q.push_back(c0 + 1 + RD_LAT + i);
         end
      end
      step();
      step();
      sclr = 1'b1;
      #1;
      check("sclr_ready_low", 32'(ready), 32'd0);
      step();
      sclr = 1'b0;
      #1;
      check("sclr_ready_back", 32'(ready), 32'd1);
      check("sclr_cmd_err_clr", 32'(cmd_err), 32'd0);
      repeat (12) step();
      check("sclr_idle", {30'd0, use_wdata, ready}, 32'd1);
      wait_drain();
      for (int i = 0; i < 8; i++) exp_buf[i] = 32'h100 + 32'(i);
      do_read(2'd2, 12'd3, 8'h40, 4'd7, 4'd9);
      for (int i = 0; i < 4; i++) exp_buf[i] = 32'hA0 + 32'(i);
      do_read(2'd1, 12'd5, 8'h10, 4'd3, 4'd2);
      wait_drain();
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
